// File: rtl/sd_width_pkg.sv
// -----------------------------------------------------------------------------
// sd_width_pkg
// Shared definitions for the srdy/drdy width conversion stages.
//   phase_e        : which half of a word the next accepted beat carries
//   SD_WIDTH_CNT_W : width of the optional producer-transfer counter
//   hw_of()        : half-beat width for a given full width and pad setting
// -----------------------------------------------------------------------------
package sd_width_pkg;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } phase_e;

  localparam int SD_WIDTH_CNT_W = 16;

  // An odd width is padded by one bit so that both halves are equal.
  function automatic int hw_of(input int width, input int adj_bits);
    return (width + adj_bits) / 2;
  endfunction

endpackage

// File: rtl/sd_width_demux2_obuf.sv
// -----------------------------------------------------------------------------
// sd_width_demux2_obuf
// Single-entry output holding register with srdy/drdy on the producer side.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous, active-low reset
//   ld_req_i   : upstream has a complete word to load
//   ld_data_i  : word to load
//   ld_rdy_o   : register can take a word this cycle (empty, or draining now)
//   p_srdy_o   : held word valid
//   p_drdy_i   : downstream accepts the held word
//   p_data_o   : held word
// -----------------------------------------------------------------------------
module sd_width_demux2_obuf #(
  parameter int width = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_req_i,
  input  logic [width-1:0] ld_data_i,
  output logic             ld_rdy_o,
  output logic             p_srdy_o,
  input  logic             p_drdy_i,
  output logic [width-1:0] p_data_o
);

  logic             p_srdy_q, p_srdy_d;
  logic [width-1:0] p_data_q, p_data_d;
  logic             ld_fire;

  // Ready depends only on the held state and p_drdy, never on ld_req_i,
  // so upstream valid cannot ripple through to the producer side.
  assign ld_rdy_o = ~p_srdy_q | p_drdy_i;
  assign ld_fire  = ld_req_i & ld_rdy_o;

  always_comb begin
    p_srdy_d = p_srdy_q;
    p_data_d = p_data_q;
    if (ld_fire) begin
      // A drain and a load on the same edge keep the register full.
      p_srdy_d = 1'b1;
      p_data_d = ld_data_i;
    end else if (p_drdy_i) begin
      p_srdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      p_srdy_q <= 1'b0;
      p_data_q <= '0;
    end else begin
      p_srdy_q <= p_srdy_d;
      p_data_q <= p_data_d;
    end
  end

  assign p_srdy_o = p_srdy_q;
  assign p_data_o = p_data_q;

endmodule

// File: rtl/sd_width_demux2.sv
// -----------------------------------------------------------------------------
// sd_width_demux2
// Pairs consecutive half-width beats (low half first) into one full-width word.
// Receive-side partner of the two-beat width enmuxer.
// Parameters:
//   width    : full output word width
//   adj_bits : 0 or 1; with 1 an odd width is padded and the top pad bit of the
//              assembled word is dropped
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous, active-low reset
//   c_srdy   : consumer beat valid
//   c_drdy   : consumer beat accepted (combinational from phase and p_drdy)
//   c_data   : half-width beat
//   p_srdy   : assembled word valid
//   p_drdy   : downstream accepts the word
//   p_data   : assembled word
//   p_count  : producer transfer count, wraps (only with SD_WIDTH_DEMUX2_COUNT_EN)
// Optional feature macro: SD_WIDTH_DEMUX2_COUNT_EN
//
// State table:
//   LOW  | next accepted beat is the lower half; always ready
//   HIGH | next accepted beat is the upper half; ready when output can load
// -----------------------------------------------------------------------------
module sd_width_demux2
  import sd_width_pkg::*;
#(
  parameter  int width    = 10,
  parameter  int adj_bits = 0,
  localparam int HW       = hw_of(width, adj_bits)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      c_srdy,
  output logic                      c_drdy,
  input  logic [HW-1:0]             c_data,
  output logic                      p_srdy,
  input  logic                      p_drdy,
  output logic [width-1:0]          p_data
`ifdef SD_WIDTH_DEMUX2_COUNT_EN
  ,
  output logic [SD_WIDTH_CNT_W-1:0] p_count
`endif
);

  phase_e            phase_q, phase_d;
  logic [HW-1:0]     low_half_q, low_half_d;
  logic              low_ld;
  logic              obuf_req;
  logic              obuf_rdy;
  logic [2*HW-1:0]   pair_word;
  logic [width-1:0]  ld_word;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= LOW;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Next-state logic
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      LOW: begin
        if (c_srdy) phase_d = HIGH;
      end
      HIGH: begin
        if (c_srdy && obuf_rdy) phase_d = LOW;
      end
      default: phase_d = LOW;
    endcase
  end

  // Output logic
  always_comb begin
    c_drdy   = 1'b1;
    low_ld   = 1'b0;
    obuf_req = 1'b0;
    case (phase_q)
      LOW: begin
        low_ld = c_srdy;
      end
      HIGH: begin
        c_drdy   = obuf_rdy;
        obuf_req = c_srdy;
      end
      default: begin
        c_drdy = 1'b1;
      end
    endcase
  end

  // Lower-half holding register. A half left here by a reset mid-pair is
  // harmless: reset returns the phase to LOW, so it is overwritten first.
  always_comb begin
    low_half_d = low_half_q;
    if (low_ld) low_half_d = c_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      low_half_q <= '0;
    end else begin
      low_half_q <= low_half_d;
    end
  end

  // With adj_bits=1 the pair is one bit wider than the word; the pad bit
  // sits at the top and is dropped here.
  assign pair_word = {c_data, low_half_q};
  assign ld_word   = pair_word[width-1:0];

  sd_width_demux2_obuf #(
    .width (width)
  ) u_obuf (
    .clk       (clk),
    .reset     (reset),
    .ld_req_i  (obuf_req),
    .ld_data_i (ld_word),
    .ld_rdy_o  (obuf_rdy),
    .p_srdy_o  (p_srdy),
    .p_drdy_i  (p_drdy),
    .p_data_o  (p_data)
  );

`ifdef SD_WIDTH_DEMUX2_COUNT_EN
  logic [SD_WIDTH_CNT_W-1:0] p_count_q, p_count_d;

  always_comb begin
    p_count_d = p_count_q;
    if (p_srdy && p_drdy) p_count_d = p_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      p_count_q <= '0;
    end else begin
      p_count_q <= p_count_d;
    end
  end

  assign p_count = p_count_q;
`endif

endmodule

// File: tb/tb_sd_width_demux2.sv
module tb_sd_width_demux2;

  localparam int W  = 10;
  localparam int HW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          c_srdy = 1'b0;
  logic          c_drdy;
  logic [HW-1:0] c_data = '0;
  logic          p_srdy;
  logic          p_drdy = 1'b0;
  logic [W-1:0]  p_data;
`ifdef SD_WIDTH_DEMUX2_COUNT_EN
  logic [15:0]   p_count;
`endif

  always #5 clk = ~clk;

  sd_width_demux2 #(.width(W), .adj_bits(0)) dut (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (c_srdy),
    .c_drdy (c_drdy),
    .c_data (c_data),
    .p_srdy (p_srdy),
    .p_drdy (p_drdy),
    .p_data (p_data)
`ifdef SD_WIDTH_DEMUX2_COUNT_EN
    ,
    .p_count(p_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rx_count = 0;
  logic [W-1:0] sent_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending lower half (if any) and at most one finished
  // word waiting for the consumer downstream.
  logic          m_half_v = 1'b0;
  logic [HW-1:0] m_half   = '0;
  logic          m_out_v  = 1'b0;
  logic [W-1:0]  m_out    = '0;
  int            m_cnt    = 0;

  function automatic logic model_rdy();
    return !m_half_v || !m_out_v || p_drdy;
  endfunction

  always @(posedge clk) begin : model
    logic cx, px;
    if (!reset) begin
      m_half_v <= 1'b0;
      m_half   <= '0;
      m_out_v  <= 1'b0;
      m_out    <= '0;
      m_cnt    <= 0;
    end else begin
      cx = c_srdy && model_rdy();
      px = m_out_v && p_drdy;
      if (px) m_cnt <= m_cnt + 1;
      if (cx && m_half_v) begin
        m_out    <= {c_data, m_half};
        m_out_v  <= 1'b1;
        m_half_v <= 1'b0;
      end else begin
        if (px) m_out_v <= 1'b0;
        if (cx) begin
          m_half   <= c_data;
          m_half_v <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("c_drdy", {31'b0, c_drdy}, {31'b0, model_rdy()});
      check("p_srdy", {31'b0, p_srdy}, {31'b0, m_out_v});
      if (m_out_v) check("p_data", {22'b0, p_data}, {22'b0, m_out});
`ifdef SD_WIDTH_DEMUX2_COUNT_EN
      check("p_count", {16'b0, p_count}, {16'b0, 16'(m_cnt)});
`endif
      if (p_srdy && p_drdy) begin
        rx_count++;
        if (sent_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_order: got %0h expected none (nothing sent)", p_data);
        end else begin
          check("sb_order", {22'b0, p_data}, {22'b0, sent_q.pop_front()});
        end
      end
    end
  end

  task automatic send_beat(input logic [HW-1:0] b, output int waited);
    logic acc;
    waited = 0;
    acc = 1'b0;
    c_srdy = 1'b1;
    c_data = b;
    while (!acc && waited <= 100) begin
      @(negedge clk);
      acc = c_drdy;
      @(posedge clk);
      #1;
      if (!acc) waited++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: got no accept expected accept for beat %0h", b);
    end
    c_srdy = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, output int waited);
    int w0, w1;
    sent_q.push_back(w);
    send_beat(w[4:0], w0);
    send_beat(w[9:5], w1);
    waited = w0 + w1;
  endtask

  task automatic run_pattern(input logic [7:0] sp, input logic [7:0] dp, input int nw);
    int bi, rx0, cyc;
    logic acc;
    logic [W-1:0] w;
    bi  = 0;
    cyc = 0;
    rx0 = rx_count;
    while ((bi < 2 * nw || sent_q.size() != 0) && cyc < nw * 40) begin
      w      = W'((bi / 2) * 37 + 11);
      c_srdy = sp[cyc % 8] && (bi < 2 * nw);
      c_data = bi[0] ? w[9:5] : w[4:0];
      p_drdy = dp[cyc % 8];
      @(negedge clk);
      acc = c_srdy && c_drdy;
      @(posedge clk);
      #1;
      if (acc) begin
        if (!bi[0]) sent_q.push_back(w);
        bi++;
      end
      cyc++;
    end
    c_srdy = 1'b0;
    p_drdy = 1'b1;
    check("pattern_words", rx_count - rx0, nw);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt, total_wait, rx0;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_p_srdy", {31'b0, p_srdy}, 0);
    check("rst_c_drdy", {31'b0, c_drdy}, 1);
    check("rst_p_data", {22'b0, p_data}, 0);
`ifdef SD_WIDTH_DEMUX2_COUNT_EN
    check("rst_p_count", {16'b0, p_count}, 0);
`endif
    @(posedge clk);
    #1;
    reset  = 1'b1;
    p_drdy = 1'b1;

    // Basic pairing: 5'h15 low, 5'h0A high -> 10'h155
    sent_q.push_back(10'h155);
    send_beat(5'h15, wt);
    send_beat(5'h0A, wt);
    @(negedge clk);
    check("basic_p_srdy", {31'b0, p_srdy}, 1);
    check("basic_p_data", {22'b0, p_data}, 10'h155);
    @(posedge clk);
    #1;

    // Backpressure: word A held, low half of B absorbed, high half stalls
    p_drdy = 1'b0;
    send_word(10'h2C3, wt);
    sent_q.push_back(10'h1E6);
    send_beat(5'h06, wt);
    check("bp_low_accept_wait", wt, 0);
    c_srdy = 1'b1;
    c_data = 5'h0F;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_c_drdy", {31'b0, c_drdy}, 0);
      check("bp_hold_p_data", {22'b0, p_data}, 10'h2C3);
      @(posedge clk);
      #1;
    end
    p_drdy = 1'b1;
    @(negedge clk);
    check("bp_release_c_drdy", {31'b0, c_drdy}, 1);
    @(posedge clk);
    #1;
    c_srdy = 1'b0;
    @(negedge clk);
    check("bp_word2_p_srdy", {31'b0, p_srdy}, 1);
    check("bp_word2_p_data", {22'b0, p_data}, 10'h1E6);
    @(posedge clk);
    #1;

    // Continuous streaming, 100 incrementing words crossing the 10-bit wrap
    rx0 = rx_count;
    total_wait = 0;
    for (int i = 0; i < 100; i++) begin
      send_word(W'(i + 976), wt);
      total_wait += wt;
    end
    check("stream_stalls", total_wait, 0);
    repeat (2) @(posedge clk);
    #1;
    check("stream_words", rx_count - rx0, 100);

    // Reset mid-pair discards the stale lower half
    send_beat(5'h1F, wt);
    reset = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_p_srdy", {31'b0, p_srdy}, 0);
    check("midrst_c_drdy", {31'b0, c_drdy}, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_word(10'h001, wt);
    @(negedge clk);
    check("midrst_p_data", {22'b0, p_data}, 10'h001);
    @(posedge clk);
    #1;

    // Irregular handshake patterns
    run_pattern(8'hFD, 8'h03, 1500);
    run_pattern(8'h11, 8'hEE, 1500);
    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", sent_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
